// File: rtl/flag_branch_pkg.sv
// Shared constants for the flag/branch unit: condition codes, flag bit positions, default widths.
package flag_branch_pkg;

  localparam int DEFAULT_COND_W = 4;
  localparam int DEFAULT_ADDR_W = 16;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_EQ     = 4'd1;
  localparam logic [3:0] COND_NE     = 4'd2;
  localparam logic [3:0] COND_CS     = 4'd3;
  localparam logic [3:0] COND_CC     = 4'd4;
  localparam logic [3:0] COND_MI     = 4'd5;
  localparam logic [3:0] COND_PL     = 4'd6;
  localparam logic [3:0] COND_VS     = 4'd7;
  localparam logic [3:0] COND_VC     = 4'd8;
  localparam logic [3:0] COND_HI     = 4'd9;
  localparam logic [3:0] COND_LS     = 4'd10;
  localparam logic [3:0] COND_GE     = 4'd11;
  localparam logic [3:0] COND_LT     = 4'd12;
  localparam logic [3:0] COND_GT     = 4'd13;
  localparam logic [3:0] COND_LE     = 4'd14;
  localparam logic [3:0] COND_NEVER  = 4'd15;

  localparam int FLAG_OF = 3;
  localparam int FLAG_SF = 2;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_CF = 0;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational condition-code evaluator. Signed compares (GE/LT/GT/LE) exist only
// when FLAG_BRANCH_SIGNED_EN is defined; otherwise those codes are never taken.
module cond_eval
  import flag_branch_pkg::*;
#(
  parameter int COND_W = DEFAULT_COND_W
) (
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        flags,
  output logic              taken
);

  logic ofFlag, sfFlag, zfFlag, cfFlag;

  assign ofFlag = flags[FLAG_OF];
  assign sfFlag = flags[FLAG_SF];
  assign zfFlag = flags[FLAG_ZF];
  assign cfFlag = flags[FLAG_CF];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = zfFlag;
      COND_NE:     taken = !zfFlag;
      COND_CS:     taken = cfFlag;
      COND_CC:     taken = !cfFlag;
      COND_MI:     taken = sfFlag;
      COND_PL:     taken = !sfFlag;
      COND_VS:     taken = ofFlag;
      COND_VC:     taken = !ofFlag;
      COND_HI:     taken = cfFlag && !zfFlag;
      COND_LS:     taken = !cfFlag || zfFlag;
`ifdef FLAG_BRANCH_SIGNED_EN
      COND_GE:     taken = (sfFlag == ofFlag);
      COND_LT:     taken = (sfFlag != ofFlag);
      COND_GT:     taken = !zfFlag && (sfFlag == ofFlag);
      COND_LE:     taken = zfFlag || (sfFlag != ofFlag);
`else
      COND_GE, COND_LT, COND_GT, COND_LE: taken = 1'b0;
`endif
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flags register, PC register and one-entry branch result buffer with valid/ready on both sides.
// Signed condition codes are enabled by defining FLAG_BRANCH_SIGNED_EN (see cond_eval).
module flag_branch_unit
  import flag_branch_pkg::*;
#(
  parameter int                COND_W   = DEFAULT_COND_W,
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flags_we,
  input  logic              of_in,
  input  logic              sf_in,
  input  logic              zf_in,
  input  logic              cf_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [COND_W-1:0] req_cond,
  input  logic [ADDR_W-1:0] req_target,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags_q
);

  res_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic [3:0]        flags_d;
  logic [3:0]        flagsIn;
  logic [3:0]        evalFlags;
  logic              condTaken;
  logic              accept;

  assign flagsIn   = {of_in, sf_in, zf_in, cf_in};
  // Same-cycle flag writes are forwarded so a branch right after a compare sees fresh flags.
  assign evalFlags = flags_we ? flagsIn : flags_q;

  assign res_valid = (state_q == RES_FULL);
  assign req_ready = !res_valid || res_ready;
  assign accept    = req_valid && req_ready;
  assign pc        = pc_q;
  assign res_taken = taken_q;

  cond_eval #(
    .COND_W (COND_W)
  ) u_cond_eval (
    .cond  (req_cond),
    .flags (evalFlags),
    .taken (condTaken)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    flags_d = flags_we ? flagsIn : flags_q;

    case (state_q)
      RES_EMPTY: if (accept) state_d = RES_FULL;
      RES_FULL: begin
        if (accept)         state_d = RES_FULL;
        else if (res_ready) state_d = RES_EMPTY;
      end
      default: state_d = RES_EMPTY;
    endcase

    if (accept) begin
      pc_d    = condTaken ? req_target : pc_q + ADDR_W'(1);
      taken_d = condTaken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RES_EMPTY;
      pc_q    <= PC_RESET;
      taken_q <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      flags_q <= flags_d;
    end
  end

endmodule
